// File: rtl/tiger_pipectl.sv
// Pipeline sequencer for the tiger core family: generates the stall/clear
// pair for every pipeline register, tracks which slots hold live
// instructions, and keeps cycle/retire/stall performance counters.
module tiger_pipectl #(
    parameter int STAGES    = 5,
    parameter int REGNUM_W  = 5,
    parameter int LOAD_DIST = 2,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetchValid,
    input  logic                         iStall,
    input  logic                         dStall,
    input  logic                         stall_cpu,
    input  logic [STAGES-1:0]            stallRq,
    input  logic                         flushRq,
    input  logic [2:0]                   flushSlot,
    input  logic [REGNUM_W-1:0]          rsDe,
    input  logic [REGNUM_W-1:0]          rtDe,
    input  logic                         useRsDe,
    input  logic                         useRtDe,
    input  logic [STAGES*REGNUM_W-1:0]   wrNum,
    input  logic [STAGES-1:0]            isLoad,
    output logic [STAGES-1:0]            stall,
    output logic [STAGES-1:0]            clear,
    output logic [STAGES-1:0]            valid,
    output logic                         retire,
    input  logic                         cntClr,
    output logic [CNT_W-1:0]             cycleCnt,
    output logic [CNT_W-1:0]             retireCnt,
    output logic [CNT_W-1:0]             stallCnt
);

    logic                freeze;
    logic                rqAny;
    logic                hazard;
    logic                holdAny;
    logic [REGNUM_W-1:0] wr;
    int                  fsEff;
    int                  rqTop;

    // Only the slots inside the load-use window are compared; the other
    // destination/load bits are deliberately left unused.
    logic unusedBits;
    assign unusedBits = ^{wrNum, isLoad};

    assign freeze = dStall | stall_cpu;

    // Per-slot stall/clear, resolved in priority order:
    // flush, freeze, stalled prefix (stallRq / load-use), iStall, advance.
    always_comb begin
        stall   = '0;
        clear   = '0;
        wr      = '0;
        rqAny   = 1'b0;
        rqTop   = 0;
        hazard  = 1'b0;

        // Flush index beyond the last slot saturates to the writeback slot.
        fsEff = ({29'b0, flushSlot} >= STAGES) ? STAGES - 1 : {29'b0, flushSlot};

        // Highest live slot asking for another cycle; everything below it
        // must hold so that no instruction overtakes it.
        for (int k = 0; k < STAGES; k++) begin
            if (stallRq[k] && valid[k]) begin
                rqAny = 1'b1;
                rqTop = k;
            end
        end

        // Load in slots 1..LOAD_DIST writing a register that slot 0 reads.
        // Register 0 is hard-wired, so it never creates a dependency.
        for (int j = 1; j <= LOAD_DIST; j++) begin
            wr = wrNum[j*REGNUM_W +: REGNUM_W];
            if (valid[j] && isLoad[j] && (wr != '0) &&
                ((useRsDe && (wr == rsDe)) || (useRtDe && (wr == rtDe)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & valid[0];

        // A load-use hazard stalls only slot 0, so merging it with a
        // stallRq prefix just means keeping rqTop (which is 0 if no request).
        holdAny = rqAny | hazard;

        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                clear[k] = 1'b1;
            end else if (flushRq && (k <= fsEff)) begin
                clear[k] = 1'b1;
            end else if (freeze) begin
                stall[k] = 1'b1;
            end else if (holdAny && (k <= rqTop)) begin
                stall[k] = 1'b1;
            end else if (holdAny && (k == rqTop + 1)) begin
                clear[k] = 1'b1;
            end else if (iStall && (k == 0)) begin
                clear[k] = 1'b1;
            end
        end
    end

    assign retire = valid[STAGES-1] & ~stall[STAGES-1] & ~clear[STAGES-1];

    // Slot occupancy follows the same stall/clear the pipeline registers see.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (clear[0]) begin
                valid[0] <= 1'b0;
            end else if (!stall[0]) begin
                valid[0] <= fetchValid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (clear[k]) begin
                    valid[k] <= 1'b0;
                end else if (!stall[k]) begin
                    valid[k] <= valid[k-1];
                end
            end
        end
    end

    // Free-running cycle counter; cntClr wins over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCnt <= '0;
        end else if (cntClr) begin
            cycleCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
        end
    end

    // Retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retireCnt <= '0;
        end else if (cntClr) begin
            retireCnt <= '0;
        end else if (retire) begin
            retireCnt <= retireCnt + CNT_W'(1);
        end
    end

    // Counts cycles where the decode-input register is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (cntClr) begin
            stallCnt <= '0;
        end else if (stall[0]) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/tiger_pipectl.md
Name: tiger_pipectl

Overview:
- Parametrised pipeline sequencer for the tiger core family. Generalises fixed 5-stage stall/clear logic to STAGES pipeline slots.
- Adds per-slot valid tracking, per-stage multicycle stall requests, targeted flush, configurable load-use distance and retire/stall performance counters.
- Sits beside the stage modules; drives every pipeline register's stall/clear pair.

Parameters:
- STAGES, 5, number of pipeline slots; slot 0 = decode-input register, slot STAGES-1 = writeback register; legal range 3..8.
- REGNUM_W, 5, register-number width.
- LOAD_DIST, 2, number of slots after slot 0 (slots 1..LOAD_DIST) checked for load-use hazards; must be < STAGES.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- fetchValid  in  1  fetch presents a real instruction this cycle
- iStall  in  1  instruction memory not ready
- dStall  in  1  data memory not ready
- stall_cpu  in  1  accelerator holds CPU
- stallRq  in  STAGES  stallRq[k]=1: unit in slot k needs another cycle
- flushRq  in  1  flush request (branch mispredict/exception)
- flushSlot  in  3  highest slot index to flush
- rsDe, rtDe  in  REGNUM_W each  source registers of slot-0 instruction
- useRsDe, useRtDe  in  1 each  sources actually read
- wrNum  in  STAGES*REGNUM_W  destination register of each slot, packed, slot k at [k*REGNUM_W +: REGNUM_W]
- isLoad  in  STAGES  slot k holds a load
- stall  out  STAGES  hold slot k register
- clear  out  STAGES  load bubble into slot k register
- valid  out  STAGES  slot k holds a live instruction
- retire  out  1  instruction leaves last slot this cycle
- cntClr  in  1  synchronous clear of all counters
- cycleCnt, retireCnt, stallCnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async): valid=0, all counters=0. While reset is high: clear=all 1, stall=0, retire=0.
- stall/clear are combinational from inputs and valid. valid and counters are registered.
- Priority per slot, highest first: flush, freeze, stallRq, load-use, iStall, advance.
- Flush: flushRq=1 gives clear[k]=1 and stall[k]=0 for k<=flushSlot. flushSlot>=STAGES is treated as STAGES-1. Slots above flushSlot follow the lower rules.
- Freeze: dStall or stall_cpu gives stall=all 1 and clear=0 on non-flushed slots.
- stallRq: let m be the highest k with stallRq[k]=1 and valid[k]=1.
  - Slots 0..m: stall=1.
  - Slot m+1 (if it exists): clear=1.
  - Slots above m+1: advance.
  - stallRq on an invalid slot is ignored.
- Load-use: hazard=1 when some j in 1..LOAD_DIST has valid[j], isLoad[j], wrNum[j]!=0 and wrNum[j] equals rsDe (with useRsDe) or rtDe (with useRtDe), and valid[0]=1. Effect: stall[0]=1 and clear[1]=1. Merges with stallRq by taking the larger stalled prefix.
- iStall alone: clear[0]=1; slots >=1 advance.
- Valid update per clock:
  - clear[k] gives valid[k]<=0.
  - Else stall[k] gives hold.
  - Else valid[k]<=valid[k-1], and valid[0]<=fetchValid.
- retire = valid[STAGES-1] & ~stall[STAGES-1] & ~clear[STAGES-1].
- Counters: cycleCnt increments every cycle; retireCnt increments on retire; stallCnt increments when stall[0]=1.
- All counters wrap modulo 2^CNT_W. cntClr=1 sets them to 0 on that edge, taking precedence over increment.
- Flush and freeze in the same cycle: flushed slots clear; remaining slots freeze.
- Reset asserted mid-operation: valid drops to 0 immediately; no retire is counted.

Test Plan:
- Reset, then fetchValid=1 for 10 cycles with no stalls -> valid fills one slot per cycle; first retire at cycle 5 (STAGES=5); retireCnt=6 after cycle 10.
- Slot 2 holds a valid load with wrNum=7; slot 0 has rsDe=7, useRsDe=1 -> stall=00001, clear=00010 for one cycle; stallCnt+1; repeat with wrNum=0 -> no stall.
- stallRq[2]=1 for 3 cycles on a valid slot 2 -> stall=00111 and clear=01000 each of the 3 cycles; slots 3-4 drain; valid[3]=0 afterwards.
- flushRq=1, flushSlot=1 together with dStall=1 -> clear=00011, stall=11100; valid[1:0]=0 next cycle; valid[4:2] held.
- Counters at 2^CNT_W-1 (CNT_W=4 build), one more cycle -> cycleCnt wraps to 0; cntClr together with retire -> retireCnt=0.
- Assert reset asynchronously mid-stream with 4 valid slots -> valid=0 before the next edge; clear=11111; counters=0.
